// File: rtl/csi2_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csi2_rx_pkg
//  Description : Shared constants and types for the CSI-2 / D-PHY receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package csi2_rx_pkg;

    // HS leader/sync byte in bit-transmission order (bit 0 is received first).
    localparam logic [7:0] DPHY_SYNC_BYTE = 8'hB8;

    // Byte aligner lane states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HUNT     = 2'd1,
        LOCKED   = 2'd2,
        WAIT_END = 2'd3
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/dphy_sync_search.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_sync_search
//  Description : Combinational sync-pattern search over a 16-bit window.
//                Reports whether the pattern appears at any of the eight bit
//                offsets and returns the lowest matching offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dphy_sync_search (
    input  logic [15:0] window_i,
    input  logic [7:0]  pattern_i,
    output logic        found_o,
    output logic [2:0]  offset_o
);

    logic [7:0] w_match;

    // One comparator per candidate bit offset.
    for (genvar o = 0; o < 8; o++) begin : g_match
        assign w_match[o] = (window_i[o +: 8] == pattern_i);
    end

    // Priority encode: the lowest matching offset wins.
    always_comb begin
        found_o  = |w_match;
        offset_o = 3'd0;
        for (int o = 7; o >= 0; o--) begin
            if (w_match[o]) begin
                offset_o = 3'(o);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dphy_byte_align.sv
`default_nettype none
// ============================================================================
//  Module      : dphy_byte_align
//  Description : D-PHY HS byte aligner. Hunts for the sync byte in the raw
//                deserializer stream, locks the bit offset and emits aligned
//                payload bytes. Flags a hunt timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module dphy_byte_align
    import csi2_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DPHY_SYNC_BYTE,
    parameter int         SYNC_TIMEOUT = 32
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       hs_active_i,
    input  logic [7:0] byte_data_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       sync_det_o,
    output logic       sync_err_o,
    output logic [2:0] offset_o
);

    // Counter value seen on the last allowed hunt cycle.
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

    align_state_t state_q, state_d;
    logic [7:0]   prev_q, prev_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [2:0]   offset_q, offset_d;
    logic [7:0]   byte_data_q, byte_data_d;
    logic         byte_valid_q, byte_valid_d;
    logic         sync_det_q, sync_det_d;
    logic         sync_err_q, sync_err_d;

    logic [15:0]  w_window;
    logic         w_found;
    logic [2:0]   w_found_off;
    logic [7:0]   w_aligned;

    assign w_window  = {byte_data_i, prev_q};
    assign w_aligned = w_window[offset_q +: 8];

    dphy_sync_search u_search (
        .window_i  (w_window),
        .pattern_i (SYNC_BYTE),
        .found_o   (w_found),
        .offset_o  (w_found_off)
    );

    // Next-state and output logic; leaving HS always wins over a match.
    always_comb begin
        state_d      = state_q;
        prev_d       = hs_active_i ? byte_data_i : 8'h00;
        cnt_d        = cnt_q;
        offset_d     = offset_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        sync_det_d   = 1'b0;
        sync_err_d   = 1'b0;

        if (!hs_active_i) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                // The first HS cycle is searched straight from IDLE.
                IDLE, HUNT: begin
                    if (w_found) begin
                        state_d    = LOCKED;
                        offset_d   = w_found_off;
                        sync_det_d = 1'b1;
                        cnt_d      = 8'd0;
                    end else if (cnt_q >= C_TIMEOUT_LAST) begin
                        state_d    = WAIT_END;
                        sync_err_d = 1'b1;
                        cnt_d      = 8'd0;
                    end else begin
                        state_d = HUNT;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
                // Payload is passed through untouched; no re-search.
                LOCKED: begin
                    byte_data_d  = w_aligned;
                    byte_valid_d = 1'b1;
                end
                // Sit out the rest of a burst that never synced.
                WAIT_END: begin
                    state_d = WAIT_END;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            prev_q       <= 8'h00;
            cnt_q        <= 8'd0;
            offset_q     <= 3'd0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            sync_det_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            offset_q     <= offset_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            sync_det_q   <= sync_det_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign byte_data_o  = byte_data_q;
    assign byte_valid_o = byte_valid_q;
    assign sync_det_o   = sync_det_q;
    assign sync_err_o   = sync_err_q;
    assign offset_o     = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_dphy_byte_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dphy_byte_align
//  Description : Self-checking bench for dphy_byte_align. Directed vector
//                table, hand-written corner sequences and random bursts
//                checked against a bit-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dphy_byte_align;

    localparam int         SYNC_TIMEOUT = 32;
    localparam logic [7:0] SYNC         = 8'hB8;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid;
    logic       det;
    logic       err;
    logic [2:0] off;

    always #5 clk = ~clk;

    dphy_byte_align #(
        .SYNC_BYTE    (SYNC),
        .SYNC_TIMEOUT (SYNC_TIMEOUT)
    ) dut (
        .byte_clk_i   (clk),
        .rst_i        (rst),
        .hs_active_i  (hs),
        .byte_data_i  (din),
        .byte_data_o  (dout),
        .byte_valid_o (valid),
        .sync_det_o   (det),
        .sync_err_o   (err),
        .offset_o     (off)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: bit stream of the current burst -----
    bit         sb[$];
    int         m_mode;      // 0 hunting, 1 locked, 2 waiting for end of burst
    int         m_hunt;
    int         m_sync_pos;
    int         m_k;
    logic       e_valid, e_det, e_err;
    logic [7:0] e_data;
    logic [2:0] e_off;

    function automatic logic [7:0] byte_at(input int idx);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = sb[idx + j];
        return r;
    endfunction

    task automatic model_reset();
        sb.delete();
        m_mode = 0; m_hunt = 0; m_sync_pos = 0; m_k = 0;
        e_valid = 0; e_det = 0; e_err = 0; e_data = 8'h00; e_off = 3'd0;
    endtask

    task automatic model_step(input logic h, input logic [7:0] d);
        int n;
        int found;
        e_valid = 0; e_det = 0; e_err = 0;
        if (!h) begin
            sb.delete();
            m_mode = 0;
            m_hunt = 0;
            return;
        end
        if (sb.size() == 0) for (int j = 0; j < 8; j++) sb.push_back(1'b0);
        for (int j = 0; j < 8; j++) sb.push_back(d[j]);
        n = sb.size();
        if (m_mode == 1) begin
            m_k++;
            e_data  = byte_at(m_sync_pos + 8 * m_k);
            e_valid = 1;
        end else if (m_mode == 0) begin
            m_hunt++;
            found = -1;
            for (int o = 0; o < 8; o++)
                if (found < 0 && byte_at(n - 16 + o) == SYNC) found = o;
            if (found >= 0) begin
                m_mode     = 1;
                m_sync_pos = n - 16 + found;
                m_k        = 0;
                e_det      = 1;
                e_off      = 3'(found);
            end else if (m_hunt == SYNC_TIMEOUT) begin
                m_mode = 2;
                e_err  = 1;
            end
        end
    endtask

    // Drive one cycle, advance the model, compare every output to it.
    task automatic step(input logic h, input logic [7:0] d);
        hs  = h;
        din = d;
        @(posedge clk);
        #1;
        model_step(h, d);
        check("model_valid", 32'(valid), 32'(e_valid));
        check("model_det",   32'(det),   32'(e_det));
        check("model_err",   32'(err),   32'(e_err));
        check("model_off",   32'(off),   32'(e_off));
        if (e_valid) check("model_data", 32'(dout), 32'(e_data));
    endtask

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic       hs;
        logic [7:0] din;
        logic       v;
        logic [7:0] d;
        logic       det;
        logic       err;
        logic [2:0] off;
    } vec_t;

    vec_t tbl[19];

    int err_cnt, err_at, cnt_a, cnt_b;
    logic [7:0] pend[$];
    logic [15:0] inj;
    int o_inj;
    logic h_r;

    initial begin
        // offset 3 lock
        tbl[0]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 8'hC0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 8'hD5, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3};
        tbl[4]  = '{1'b1, 8'h02, 1'b1, 8'h5A, 1'b0, 1'b0, 3'd3};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
        // offset 0 lock, then payload containing the sync byte
        tbl[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
        tbl[7]  = '{1'b1, 8'hB8, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3};
        tbl[8]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
        tbl[9]  = '{1'b1, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, 8'h33, 1'b1, 8'h22, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b1, 8'hB8, 1'b1, 8'h33, 1'b0, 1'b0, 3'd0};
        tbl[12] = '{1'b1, 8'h44, 1'b1, 8'hB8, 1'b0, 1'b0, 3'd0};
        tbl[13] = '{1'b1, 8'h55, 1'b1, 8'h44, 1'b0, 1'b0, 3'd0};
        // end of burst, then a new burst at offset 5
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[15] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0};
        tbl[16] = '{1'b1, 8'h17, 1'b0, 8'h00, 1'b1, 1'b0, 3'd5};
        tbl[17] = '{1'b1, 8'hFF, 1'b1, 8'hF8, 1'b0, 1'b0, 3'd5};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 3'd5};

        // reset state
        rst = 1'b1; hs = 1'b0; din = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data",  32'(dout),  32'd0);
        check("reset_det",   32'(det),   32'd0);
        check("reset_err",   32'(err),   32'd0);
        check("reset_off",   32'(off),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed table
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].hs, tbl[i].din);
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_det", i),   32'(det),   32'(tbl[i].det));
            check($sformatf("tbl%0d_err", i),   32'(err),   32'(tbl[i].err));
            check($sformatf("tbl%0d_off", i),   32'(off),   32'(tbl[i].off));
            if (tbl[i].v) check($sformatf("tbl%0d_data", i), 32'(dout), 32'(tbl[i].d));
        end

        // timeout: 40 idle HS cycles, then a late sync in the same burst
        step(1'b0, 8'h00);
        err_cnt = 0; err_at = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 8'h00);
            if (err === 1'b1) begin
                err_cnt++;
                err_at = i;
            end
        end
        check("timeout_pulses", 32'(err_cnt), 32'd1);
        check("timeout_cycle",  32'(err_at),  32'(SYNC_TIMEOUT));
        cnt_a = 0;
        step(1'b1, 8'hB8); cnt_a += int'(det) + int'(valid);
        step(1'b1, 8'h11); cnt_a += int'(det) + int'(valid);
        step(1'b1, 8'h22); cnt_a += int'(det) + int'(valid);
        check("timeout_no_lock", 32'(cnt_a), 32'd0);
        // one low cycle, then relock
        step(1'b0, 8'h00);
        step(1'b1, 8'hB8);
        step(1'b1, 8'h11);
        check("relock_det", 32'(det), 32'd1);
        step(1'b1, 8'h22);
        check("relock_valid", 32'(valid), 32'd1);
        check("relock_data",  32'(dout),  32'h11);

        // async reset in the middle of a locked burst
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        step(1'b1, 8'hC0);
        step(1'b1, 8'hD5);
        step(1'b1, 8'h02);
        check("pre_rst_valid", 32'(valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_data",  32'(dout),  32'd0);
        check("arst_det",   32'(det),   32'd0);
        check("arst_err",   32'(err),   32'd0);
        check("arst_off",   32'(off),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h02);
        check("post_rst_idle", 32'(valid), 32'd0);
        step(1'b1, 8'h00);
        step(1'b1, 8'h17);
        check("post_rst_det", 32'(det), 32'd1);
        check("post_rst_off", 32'(off), 32'd5);
        step(1'b0, 8'h00);

        // randomized bursts with injected sync patterns
        cnt_b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pend.size() != 0) begin
                step(1'b1, pend.pop_front());
            end else begin
                h_r = ($urandom_range(0, 15) != 0);
                if (h_r && $urandom_range(0, 5) == 0) begin
                    inj   = 16'($urandom);
                    o_inj = int'($urandom_range(0, 7));
                    inj[o_inj +: 8] = SYNC;
                    pend.push_back(inj[15:8]);
                    step(1'b1, inj[7:0]);
                end else begin
                    step(h_r, 8'($urandom));
                end
            end
            if (det === 1'b1) cnt_b++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dphy_byte_align.md
Name: dphy_byte_align

Overview:
- Sits directly downstream of the per-lane D-PHY HS deserializer, in the byte clock domain.
- Receives raw, bit-misaligned 8-bit words from the ISERDES while the lane is in HS mode.
- Hunts for the HS leader/sync byte, locks the bit offset, and emits byte-aligned payload with a valid flag for the lane merger / packet parser.
- Reports sync timeouts.

Parameters:
- SYNC_BYTE, 8'hB8, HS sync pattern in bit-transmission order (bit 0 is received first).
- SYNC_TIMEOUT, 32, maximum byte_clk cycles spent hunting before an error is flagged; range 2..255.

Ports:
- byte_clk_i  in  1  byte clock; same clock that drives ISERDES CLKDIV.
- rst_i  in  1  reset, asynchronous, active-high.
- hs_active_i  in  1  lane in HS receive (from LP-state detector); synchronous to byte_clk_i.
- byte_data_i  in  8  raw deserialized word; bit 0 is the earliest received bit.
- byte_data_o  out  8  aligned byte; bit 0 is the earliest bit.
- byte_valid_o  out  1  byte_data_o valid.
- sync_det_o  out  1  one-cycle pulse when the sync byte is found.
- sync_err_o  out  1  one-cycle pulse on hunt timeout.
- offset_o  out  3  locked bit offset; holds its last value outside LOCKED.

Behaviour:
- Clock and reset: single clock byte_clk_i; rst_i is asynchronous and active-high.
- Reset values: all outputs 0; prev byte register 0; state IDLE; timeout counter 0.
- Window: prev_q <= byte_data_i every cycle while hs_active_i=1, else 0. w[15:0] = {byte_data_i, prev_q}.
- Search: match[o] = (w[o+7:o] == SYNC_BYTE) for o = 0..7. The selected offset is the lowest o with match set (priority encoder).
- States: IDLE, HUNT, LOCKED, WAIT_END.
- IDLE -> HUNT when hs_active_i=1. The first HS cycle is already searched, with prev_q=0.
- HUNT, any match at cycle t:
  - -> LOCKED.
  - offset_q <= selected o.
  - sync_det_o=1 at t+1.
- HUNT, no match: counter increments. When counter reaches SYNC_TIMEOUT-1 without a match -> WAIT_END, sync_err_o=1 for one cycle.
- LOCKED, each cycle: byte_data_o <= w[offset_q+7:offset_q], byte_valid_o <= 1.
  - First valid byte (at t+2) is the byte immediately following the sync.
  - No re-search while LOCKED; a repeated sync pattern in the payload is passed through as data.
- LOCKED/HUNT/WAIT_END with hs_active_i=0 -> IDLE.
  - byte_valid_o=0 from the next cycle; counter cleared.
  - A trailer byte that is partially received is dropped.
- WAIT_END: outputs idle until hs_active_i=0.
- hs_active_i dropping in the same cycle a match occurs: IDLE wins; no sync_det_o.
- hs_active_i 0->1 with only one cycle low: a fresh hunt starts; prev_q was zeroed in the low cycle.
- Latency: sync_det_o 1 cycle after the sync completes on byte_data_i; data 1 cycle after its window forms.
- rst_i mid-packet: immediate return to the reset values above. The block does not relock until hs_active_i is seen high after reset release.
- Timeout counter width: 8 bits, saturating.

Decomposition:
- Package csi2_rx_pkg holds:
  - DPHY_SYNC_BYTE = 8'hB8.
  - typedef enum logic [1:0] align_state_t {IDLE, HUNT, LOCKED, WAIT_END}.
- Sub-module dphy_sync_search: combinational, 16-bit window plus pattern in; found and 3-bit lowest offset out. It is reused by the multi-lane deskew block later.
- Everything else stays in dphy_byte_align.

Test Plan:
- Offset 3 lock: hs_active_i=1; byte_data_i 0x00, 0xC0, 0xD5, 0x02 ->
  - sync_det_o pulses the cycle after 0xD5.
  - offset_o=3.
  - byte_data_o=0x5A with byte_valid_o=1 one cycle after 0x02.
- Offset 0 lock: 0x00, 0xB8, 0x11, 0x22 ->
  - offset_o=0.
  - valid outputs are 0x11, then 0x22, each one cycle after input.
  - no valid output before sync.
- Timeout: hs_active_i=1 with constant 0x00 for 40 cycles, SYNC_TIMEOUT=32 ->
  - sync_err_o single pulse on the 32nd hunt cycle.
  - no sync_det_o or byte_valid_o, even if 0xB8 arrives later in the same burst.
  - relock succeeds after hs_active_i toggles low.
- End of burst: while LOCKED, drop hs_active_i ->
  - byte_valid_o=0 next cycle.
  - a new burst at offset 5 locks with offset_o=5.
- Payload contains 0xB8 after lock -> passed as data; offset_o unchanged; no second sync_det_o.
- Async reset asserted mid-LOCKED between clock edges -> all outputs 0 immediately; after release, state IDLE.
